// File: rtl/hub_bus_pkg.sv
// Shared constants, stage-register layout and byte-lane helpers for the hub bus slave.
package hub_bus_pkg;

  localparam logic [2:0] HUBOP_COGID   = 3'b001;
  localparam logic [2:0] HUBOP_LOCKNEW = 3'b100;
  localparam logic [2:0] HUBOP_LOCKRET = 3'b101;
  localparam logic [2:0] HUBOP_LOCKSET = 3'b110;
  localparam logic [2:0] HUBOP_LOCKCLR = 3'b111;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_WORD = 2'b01;
  localparam logic [1:0] SZ_LONG = 2'b10;

  localparam int COG_W = 3;

  typedef struct packed {
    logic             valid;
    logic [COG_W-1:0] cog;
    logic             e;
    logic             w;
    logic [1:0]       s;
    logic [1:0]       a_lo;
    logic [2:0]       code;
    logic [2:0]       id;
  } stage_t;

  // Size code 11 falls through to the long case everywhere.
  function automatic logic [3:0] write_mask(input logic [1:0] s, input logic [1:0] a_lo);
    logic [3:0] m;
    case (s)
      SZ_BYTE: m = 4'b0001 << a_lo;
      SZ_WORD: m = a_lo[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] write_data(input logic [1:0] s, input logic [31:0] d);
    logic [31:0] r;
    case (s)
      SZ_BYTE: r = {4{d[7:0]}};
      SZ_WORD: r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] read_lane(input logic [1:0] s, input logic [1:0] a_lo,
                                            input logic [31:0] q);
    logic [31:0] r;
    case (s)
      SZ_BYTE: r = {24'h0, q[{a_lo, 3'b000} +: 8]};
      SZ_WORD: r = a_lo[1] ? {16'h0, q[31:16]} : {16'h0, q[15:0]};
      default: r = q;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/hub_bus_slave_if.sv
// Cog request buses plus the hub RAM port, bundled between the hub slave and its neighbours.
interface hub_bus_slave_if #(
  parameter int COGS = 8,
  parameter int AW   = 14
);
  logic [COGS-1:0]    bus_sel;
  logic [COGS-1:0]    bus_e;
  logic [COGS-1:0]    bus_w;
  logic [2*COGS-1:0]  bus_s;
  logic [16*COGS-1:0] bus_a;
  logic [32*COGS-1:0] bus_d;
  logic [31:0]        bus_q;
  logic               bus_c;
  logic [COGS-1:0]    bus_ack;
  logic               mem_en;
  logic               mem_we;
  logic [3:0]         mem_bm;
  logic [AW-1:0]      mem_a;
  logic [31:0]        mem_d;
  logic [31:0]        mem_q;

  modport slave (
    input  bus_sel, bus_e, bus_w, bus_s, bus_a, bus_d, mem_q,
    output bus_q, bus_c, bus_ack, mem_en, mem_we, mem_bm, mem_a, mem_d
  );

  // Cog side together with the RAM model that answers mem_q.
  modport master (
    output bus_sel, bus_e, bus_w, bus_s, bus_a, bus_d, mem_q,
    input  bus_q, bus_c, bus_ack, mem_en, mem_we, mem_bm, mem_a, mem_d
  );
endinterface

// File: rtl/hub_lock_unit.sv
// Hardware lock pool: allocation and set/clear state, answered combinationally, updated on strobe.
module hub_lock_unit
  import hub_bus_pkg::*;
#(
  parameter int LOCKS = 8
) (
  input  logic        clk_cog,
  input  logic        nres,
  input  logic        stb_i,
  input  logic [2:0]  code_i,
  input  logic [2:0]  id_i,
  output logic [31:0] q_o,
  output logic        c_o
);
  logic [LOCKS-1:0] state_q, state_d;
  logic [LOCKS-1:0] alloc_q, alloc_d;
  logic             free_found;
  logic [2:0]       free_id;

  // Scan downwards so the lowest free id is the one left standing.
  always_comb begin
    free_found = 1'b0;
    free_id    = 3'd0;
    for (int i = LOCKS - 1; i >= 0; i--) begin
      if (!alloc_q[i]) begin
        free_found = 1'b1;
        free_id    = 3'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    alloc_d = alloc_q;
    q_o     = 32'h0;
    c_o     = 1'b0;
    case (code_i)
      HUBOP_LOCKNEW: begin
        if (free_found) begin
          q_o              = 32'(free_id);
          alloc_d[free_id] = 1'b1;
        end else begin
          q_o = 32'(LOCKS - 1);
          c_o = 1'b1;
        end
      end
      HUBOP_LOCKRET: begin
        q_o           = 32'(id_i);
        c_o           = &alloc_q;
        alloc_d[id_i] = 1'b0;
      end
      HUBOP_LOCKSET: begin
        q_o           = 32'(id_i);
        c_o           = state_q[id_i];
        state_d[id_i] = 1'b1;
      end
      HUBOP_LOCKCLR: begin
        q_o           = 32'(id_i);
        c_o           = state_q[id_i];
        state_d[id_i] = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_cog or negedge nres) begin
    if (!nres) begin
      state_q <= '0;
      alloc_q <= '0;
    end else if (stb_i) begin
      state_q <= state_d;
      alloc_q <= alloc_d;
    end
  end

endmodule

// File: rtl/hub_bus_slave.sv
// Round-robin hub responder: slot select + RAM issue in stage 1, result/ack in stage 2.
module hub_bus_slave
  import hub_bus_pkg::*;
#(
  parameter int COGS  = 8,
  parameter int AW    = 14,
  parameter int LOCKS = 8
) (
  input  logic           clk_cog,
  input  logic           nres,
  input  logic           ena_bus,
  hub_bus_slave_if.slave bus
);
  localparam int SW = $clog2(COGS);

  logic [1:0]  s_arr [COGS];
  logic [15:0] a_arr [COGS];
  logic [31:0] d_arr [COGS];

  for (genvar gi = 0; gi < COGS; gi++) begin : g_unpack
    assign s_arr[gi] = bus.bus_s[2*gi +: 2];
    assign a_arr[gi] = bus.bus_a[16*gi +: 16];
    assign d_arr[gi] = bus.bus_d[32*gi +: 32];
  end

  logic [SW-1:0]   slot_q;
  stage_t          st1_q, st1_d;
  logic            mem_en_q, mem_en_d;
  logic            mem_we_q, mem_we_d;
  logic [3:0]      mem_bm_q, mem_bm_d;
  logic [AW-1:0]   mem_a_q, mem_a_d;
  logic [31:0]     mem_d_q, mem_d_d;
  logic [31:0]     bus_q_q, bus_q_d;
  logic            bus_c_q, bus_c_d;
  logic [COGS-1:0] ack_q, ack_d;

  logic [15:0]     req_a;
  logic [31:0]     req_d;
  logic            lock_stb;
  logic [31:0]     lock_q;
  logic            lock_c;

  assign req_a = a_arr[slot_q];
  assign req_d = d_arr[slot_q];

  always_comb begin
    st1_d    = '0;
    mem_en_d = 1'b0;
    mem_we_d = 1'b0;
    mem_bm_d = 4'b0000;
    mem_d_d  = 32'h0;
    mem_a_d  = mem_a_q;
    if (bus.bus_sel[slot_q]) begin
      st1_d.valid = 1'b1;
      st1_d.cog   = COG_W'(slot_q);
      st1_d.e     = bus.bus_e[slot_q];
      st1_d.w     = bus.bus_w[slot_q];
      st1_d.s     = s_arr[slot_q];
      st1_d.a_lo  = req_a[1:0];
      st1_d.code  = req_a[2:0];
      st1_d.id    = req_d[2:0];
      if (!st1_d.e) begin
        mem_en_d = 1'b1;
        mem_we_d = st1_d.w;
        mem_a_d  = req_a[2 +: AW];
        if (st1_d.w) begin
          mem_bm_d = write_mask(st1_d.s, st1_d.a_lo);
          mem_d_d  = write_data(st1_d.s, req_d);
        end
      end
    end
  end

  // Results hold until the next completion; ack is a single-period pulse.
  always_comb begin
    bus_q_d  = bus_q_q;
    bus_c_d  = bus_c_q;
    ack_d    = '0;
    lock_stb = 1'b0;
    if (st1_q.valid) begin
      ack_d[st1_q.cog] = 1'b1;
      bus_c_d          = 1'b0;
      if (st1_q.e) begin
        lock_stb = ena_bus;
        case (st1_q.code)
          HUBOP_COGID: bus_q_d = 32'(st1_q.cog);
          HUBOP_LOCKNEW, HUBOP_LOCKRET, HUBOP_LOCKSET, HUBOP_LOCKCLR: begin
            bus_q_d = lock_q;
            bus_c_d = lock_c;
          end
          default: bus_q_d = 32'h0;
        endcase
      end else if (st1_q.w) begin
        bus_q_d = 32'h0;
      end else begin
        bus_q_d = read_lane(st1_q.s, st1_q.a_lo, bus.mem_q);
      end
    end
  end

  hub_lock_unit #(.LOCKS(LOCKS)) u_lock (
    .clk_cog (clk_cog),
    .nres    (nres),
    .stb_i   (lock_stb),
    .code_i  (st1_q.code),
    .id_i    (st1_q.id),
    .q_o     (lock_q),
    .c_o     (lock_c)
  );

  always_ff @(posedge clk_cog or negedge nres) begin
    if (!nres) begin
      slot_q   <= '0;
      st1_q    <= '0;
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      mem_bm_q <= 4'b0000;
      mem_a_q  <= '0;
      mem_d_q  <= 32'h0;
      bus_q_q  <= 32'h0;
      bus_c_q  <= 1'b0;
      ack_q    <= '0;
    end else if (ena_bus) begin
      slot_q   <= slot_q + SW'(1);
      st1_q    <= st1_d;
      mem_en_q <= mem_en_d;
      mem_we_q <= mem_we_d;
      mem_bm_q <= mem_bm_d;
      mem_a_q  <= mem_a_d;
      mem_d_q  <= mem_d_d;
      bus_q_q  <= bus_q_d;
      bus_c_q  <= bus_c_d;
      ack_q    <= ack_d;
    end
  end

  assign bus.bus_q   = bus_q_q;
  assign bus.bus_c   = bus_c_q;
  assign bus.bus_ack = ack_q;
  assign bus.mem_en  = mem_en_q;
  assign bus.mem_we  = mem_we_q;
  assign bus.mem_bm  = mem_bm_q;
  assign bus.mem_a   = mem_a_q;
  assign bus.mem_d   = mem_d_q;

endmodule
